// File: rtl/dcache_wt_controller.sv
// dcache_wt_controller: direct-mapped write-through, no-write-allocate data cache
// with block refill from main memory over a registered req/ack handshake.
module dcache_wt_controller #(
    parameter int ADDR_W   = 10,
    parameter int INDEX_W  = 5,
    parameter int OFFSET_W = 2,
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              mm_req,
    output logic              mm_we,
    output logic [ADDR_W-1:0] mm_addr,
    output logic [DATA_W-1:0] mm_wdata,
    input  logic [DATA_W-1:0] mm_rdata,
    input  logic              mm_ack,
    output logic [CNT_W-1:0]  rd_hit_cnt,
    output logic [CNT_W-1:0]  rd_miss_cnt
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES = 2 ** INDEX_W;
    localparam int WORDS = 2 ** OFFSET_W;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t               state_q, state_d;
    logic [LINES-1:0]     valid_q;
    logic [TAG_W-1:0]     tag_q [LINES];
    logic [DATA_W-1:0]    data_q [LINES][WORDS];
    logic [OFFSET_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic                 mm_req_q, mm_req_d, mm_we_q, mm_we_d;
    logic [ADDR_W-1:0]    mm_addr_q, mm_addr_d;
    logic [DATA_W-1:0]    mm_wdata_q, mm_wdata_d;
    logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic [TAG_W-1:0]     tag;
    logic [INDEX_W-1:0]   index;
    logic [OFFSET_W-1:0]  offset;
    logic                 hit, hit_inc, miss_inc, fill_we, fill_last, wr_hit_we;

    assign tag       = addr[ADDR_W-1 -: TAG_W];
    assign index     = addr[OFFSET_W +: INDEX_W];
    assign offset    = addr[OFFSET_W-1:0];
    assign hit       = valid_q[index] && (tag_q[index] == tag);
    assign rdata     = mem_read ? data_q[index][offset] : '0;
    assign cnt_inc   = cnt_q + 1'b1;
    assign fill_we   = (state_q == FILL) && mm_ack;
    assign fill_last = fill_we && (&cnt_q);
    assign wr_hit_we = (state_q == WRITE) && mm_ack && hit;

    assign mm_req      = mm_req_q;
    assign mm_we       = mm_we_q;
    assign mm_addr     = mm_addr_q;
    assign mm_wdata    = mm_wdata_q;
    assign rd_hit_cnt  = hit_cnt_q;
    assign rd_miss_cnt = miss_cnt_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mm_req_d   = mm_req_q;
        mm_we_d    = mm_we_q;
        mm_addr_d  = mm_addr_q;
        mm_wdata_d = mm_wdata_q;
        stall      = 1'b0;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_write) begin
                    stall      = 1'b1;
                    mm_req_d   = 1'b1;
                    mm_we_d    = 1'b1;
                    mm_addr_d  = addr;
                    mm_wdata_d = wdata;
                    state_d    = WRITE;
                end else if (mem_read && !hit) begin
                    stall     = 1'b1;
                    miss_inc  = 1'b1;
                    cnt_d     = '0;
                    mm_req_d  = 1'b1;
                    mm_we_d   = 1'b0;
                    mm_addr_d = {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    state_d   = FILL;
                end else begin
                    hit_inc = mem_read;
                end
            end
            FILL: begin
                stall = 1'b1;
                if (mm_ack && (&cnt_q)) begin
                    mm_req_d = 1'b0;
                    state_d  = DONE;
                end else if (mm_ack) begin
                    cnt_d     = cnt_inc;
                    mm_addr_d = {addr[ADDR_W-1:OFFSET_W], cnt_inc};
                end
            end
            WRITE: begin
                stall    = 1'b1;
                mm_req_d = mm_ack ? 1'b0 : mm_req_q;
                state_d  = mm_ack ? DONE : WRITE;
            end
            DONE: state_d = IDLE;
        endcase
        hit_cnt_d  = hit_cnt_q + CNT_W'(hit_inc && !(&hit_cnt_q));
        miss_cnt_d = miss_cnt_q + CNT_W'(miss_inc && !(&miss_cnt_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mm_req_q   <= 1'b0;
            mm_we_q    <= 1'b0;
            mm_addr_q  <= '0;
            mm_wdata_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mm_req_q   <= mm_req_d;
            mm_we_q    <= mm_we_d;
            mm_addr_q  <= mm_addr_d;
            mm_wdata_q <= mm_wdata_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            if (fill_last) valid_q[index] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; only valid bits are cleared.
    always_ff @(posedge clk) begin
        if (fill_we) data_q[index][cnt_q] <= mm_rdata;
        if (fill_last) tag_q[index] <= tag;
        if (wr_hit_we) data_q[index][offset] <= wdata;
    end
endmodule
